reg_file_mp: RTL

Parametrised multi-port integer register file with an integrated scoreboard, the successor to the core's fixed 2-read/1-write register file. It provides `NRD` combinational read ports, `NWR` write-back ports, a hardwired-zero register 0 and one pending-write busy bit per register. Decode uses it to read operands and detect RAW hazards. Issue reserves destinations; write-back releases them. Sits between the decode/issue stage and the write-back stage.

---
 rtl/reg_file_mp.sv | 111 +++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    input  logic                  flush
);

    logic [DATA_W-1:0] r_mem [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_nxt;

    logic [ADDR_W-1:0] w_wa [NWR];
    logic [DATA_W-1:0] w_wd [NWR];
    logic [NWR-1:0]    w_wv;

    genvar j;
    for (j = 0; j < NWR; j++) begin : g_wr
        assign w_wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
        assign w_wd[j] = wr_data[j*DATA_W +: DATA_W];
        // r0 is hardwired, so writes to it never count
        assign w_wv[j] = wr_en[j] && (w_wa[j] != '0);
    end

    // Data array; later ports are applied last so the highest index wins
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (w_wv[p]) begin
                    r_mem[w_wa[p]] <= w_wd[p];
                end
            end
        end
    end

    // Busy next state: flush, then write-back release, then issue reserve
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end
        for (int p = 0; p < NWR; p++) begin
            if (w_wv[p]) begin
                w_busy_nxt[w_wa[p]] = 1'b0;
            end
        end
        if (rsv_en && (rsv_addr != '0)) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    genvar k;
    for (k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;
        logic              w_rb;

        assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Per-port read mux, forced to zero in reset, when idle or on r0
        always_comb begin
            w_rd = '0;
            w_rb = 1'b0;
            if (nrst && rd_en[k] && (w_ra != '0)) begin
                w_rd = r_mem[w_ra];
                w_rb = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NWR; p++) begin
                    if (w_wv[p] && (w_wa[p] == w_ra)) begin
                        w_rd = w_wd[p];
                        w_rb = 1'b0;
                    end
                end
`endif
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_rd;
        assign rd_busy[k]                  = w_rb;
    end

endmodule
